// File: rtl/ehl_ahb_matrix_in_if.sv
// AHB matrix input-stage bus bundle: master-side address/data/response plus
// the broadcast and per-slave signals towards the matrix output stages.
interface ehl_ahb_matrix_in_if #(
    parameter int unsigned SNUM = 4
) ();
    logic [31:0]        im_haddr;
    logic [1:0]         im_htrans;
    logic               im_hwrite;
    logic [2:0]         im_hsize;
    logic [2:0]         im_hburst;
    logic [3:0]         im_hprot;
    logic [31:0]        im_hwdata;
    logic [31:0]        om_hrdata;
    logic               om_hready;
    logic [1:0]         om_hresp;
    logic [31:0]        os_haddr;
    logic               os_hwrite;
    logic [2:0]         os_hsize;
    logic [2:0]         os_hburst;
    logic [3:0]         os_hprot;
    logic [31:0]        os_hwdata;
    logic [SNUM*2-1:0]  os_htrans;
    logic [SNUM*32-1:0] is_hrdata;
    logic [SNUM-1:0]    is_hready;
    logic [SNUM*2-1:0]  is_hresp;

    // Input-stage view
    modport slave (
        input  im_haddr, im_htrans, im_hwrite, im_hsize, im_hburst, im_hprot, im_hwdata,
        input  is_hrdata, is_hready, is_hresp,
        output om_hrdata, om_hready, om_hresp,
        output os_haddr, os_hwrite, os_hsize, os_hburst, os_hprot, os_hwdata, os_htrans
    );

    // Surrounding master / slave-port view
    modport master (
        output im_haddr, im_htrans, im_hwrite, im_hsize, im_hburst, im_hprot, im_hwdata,
        output is_hrdata, is_hready, is_hresp,
        input  om_hrdata, om_hready, om_hresp,
        input  os_haddr, os_hwrite, os_hsize, os_hburst, os_hprot, os_hwdata, os_htrans
    );
endinterface

// File: rtl/ehl_ahb_matrix_in.sv
// AHB matrix input stage: decodes the master address onto one slave port, muxes the
// data-phase response back, and answers illegal/unmapped transfers with a 2-cycle ERROR.
module ehl_ahb_matrix_in #(
    parameter int unsigned        SNUM  = 4,
    parameter logic [SNUM*32-1:0] SBASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [SNUM*32-1:0] SMASK = {4{32'hF000_0000}}
) (
    input  logic                  hclk,
    input  logic                  hreset,
    ehl_ahb_matrix_in_if.slave    bus,
    output logic                  err_pulse,
    output logic [31:0]           err_addr
);
    localparam int unsigned SW = (SNUM > 1) ? $clog2(SNUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLV  = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  dsel_q, dsel_d;
    logic [31:0]    err_addr_q, err_addr_d;

    logic           hit;
    logic [SW-1:0]  tgt;
    logic           bad_size;
    logic           legal;
    logic           accept;
    logic           hready_c;
    logic [1:0]     hresp_c;
    logic [31:0]    hrdata_c;
    logic           sel_ready;
    logic [1:0]     sel_resp;
    logic [31:0]    sel_rdata;

    // Address decode; iterating downwards lets the lowest matching index win
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        for (int s = int'(SNUM) - 1; s >= 0; s--) begin
            if ((bus.im_haddr & SMASK[s*32 +: 32]) == SBASE[s*32 +: 32]) begin
                hit = 1'b1;
                tgt = SW'(s);
            end
        end
        bad_size = (bus.im_hsize > 3'd2)
                || ((bus.im_hsize == 3'd1) && bus.im_haddr[0])
                || ((bus.im_hsize == 3'd2) && (bus.im_haddr[1:0] != 2'b00));
        legal    = hit && !bad_size;
    end

    // Data-phase slave response selection
    always_comb begin
        sel_ready = 1'b1;
        sel_resp  = 2'b00;
        sel_rdata = '0;
        for (int unsigned s = 0; s < SNUM; s++) begin
            if (dsel_q == SW'(s)) begin
                sel_ready = bus.is_hready[s];
                sel_resp  = bus.is_hresp[s*2 +: 2];
                sel_rdata = bus.is_hrdata[s*32 +: 32];
            end
        end
    end

    // Master-facing response per state
    always_comb begin
        hready_c = 1'b1;
        hresp_c  = 2'b00;
        hrdata_c = '0;
        case (state_q)
            ST_SLV: begin
                hready_c = sel_ready;
                hresp_c  = sel_resp;
                hrdata_c = sel_rdata;
            end
            ST_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = 2'b01;
            end
            ST_ERR2: hresp_c = 2'b01;
            default: ;
        endcase
    end

    assign accept = bus.im_htrans[1] && hready_c;

    // Per-slave transfer gating; the path from is_hready through hready_c is intentional
    always_comb begin
        bus.os_htrans = '0;
        for (int unsigned s = 0; s < SNUM; s++) begin
            if (hready_c && legal && (tgt == SW'(s))) begin
                bus.os_htrans[s*2 +: 2] = bus.im_htrans;
            end
        end
    end

    // Next state; SLV only moves on once the data phase completes
    always_comb begin
        state_d    = state_q;
        dsel_d     = dsel_q;
        err_addr_d = err_addr_q;
        if (accept) begin
            if (legal) dsel_d     = tgt;
            else       err_addr_d = bus.im_haddr;
        end
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (hready_c) begin
            if (accept) state_d = legal ? ST_SLV : ST_ERR1;
            else        state_d = ST_IDLE;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            dsel_q     <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            dsel_q     <= dsel_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.om_hready = hready_c;
    assign bus.om_hresp  = hresp_c;
    assign bus.om_hrdata = hrdata_c;

    assign bus.os_haddr  = bus.im_haddr;
    assign bus.os_hwrite = bus.im_hwrite;
    assign bus.os_hsize  = bus.im_hsize;
    assign bus.os_hburst = bus.im_hburst;
    assign bus.os_hprot  = bus.im_hprot;
    assign bus.os_hwdata = bus.im_hwdata;

    assign err_pulse = (state_q == ST_ERR1);
    assign err_addr  = err_addr_q;
endmodule
